// File: rtl/udp_tx_fifo_reader.sv
`default_nettype none
// ============================================================================
// udp_tx_fifo_reader : cuts the loopback FIFO stream into UDP payloads
// Revision: 1.0
// ============================================================================
module udp_tx_fifo_reader #(
   parameter int LVL_WIDTH   = 12,
   parameter int MAX_PKT     = 1024,
   parameter int TIMEOUT_CYC = 10000
) (
   input  logic                 rd_clk,
   input  logic                 rd_rst,
   output logic                 fifo_rd_en,
   input  logic [7:0]           fifo_rd_data,
   input  logic                 fifo_empty,
   input  logic [LVL_WIDTH-1:0] fifo_water_level,
   input  logic                 tx_busy,
   input  logic                 tx_req,
   output logic                 tx_start_en,
   output logic [15:0]          tx_byte_num,
   output logic [7:0]           tx_data,
   output logic [15:0]          pkt_cnt,
   output logic                 err_underflow
);

   localparam int                   C_TMR_W   = $clog2(TIMEOUT_CYC + 1);
   localparam logic [LVL_WIDTH-1:0] C_MAX_LVL = LVL_WIDTH'(MAX_PKT);
   localparam logic [15:0]          C_MAX_LEN = 16'(MAX_PKT);
   localparam logic [C_TMR_W-1:0]   C_TIMEOUT = C_TMR_W'(TIMEOUT_CYC);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_SEND  = 2'd2,
      S_DRAIN = 2'd3
   } state_t;

   state_t             state_q, state_d;
   logic [C_TMR_W-1:0] timer_q, timer_d;
   logic [15:0]        remaining_q, remaining_d;
   logic [15:0]        len_q, len_d;
   logic [15:0]        pkt_cnt_q, pkt_cnt_d;
   logic               err_q, err_d;
   logic               w_lvl_nz;
   logic               w_lvl_full;
   logic               w_rd;

   always_comb begin
      w_lvl_nz    = (fifo_water_level != '0);
      w_lvl_full  = (fifo_water_level >= C_MAX_LVL);
      w_rd        = tx_req && (state_q == S_SEND) && (remaining_q != 16'd0);

      state_d     = state_q;
      timer_d     = '0;
      remaining_d = remaining_q;
      len_d       = len_q;
      pkt_cnt_d   = pkt_cnt_q;
      err_d       = err_q | (w_rd & fifo_empty);

      case (state_q)
         S_IDLE: begin
            // Timer only runs while a partial payload is waiting.
            if (w_lvl_nz && !w_lvl_full) begin
               timer_d = (timer_q == C_TIMEOUT) ? timer_q : timer_q + C_TMR_W'(1);
            end
            if (!tx_busy && w_lvl_full) begin
               len_d   = C_MAX_LEN;
               state_d = S_START;
               timer_d = '0;
            end else if (!tx_busy && w_lvl_nz && (timer_q == C_TIMEOUT)) begin
               len_d   = 16'(fifo_water_level);
               state_d = S_START;
               timer_d = '0;
            end
         end
         S_START: begin
            remaining_d = len_q;
            pkt_cnt_d   = pkt_cnt_q + 16'd1;
            state_d     = S_SEND;
         end
         S_SEND: begin
            if (w_rd) begin
               remaining_d = remaining_q - 16'd1;
               if (remaining_q == 16'd1) begin
                  state_d = S_DRAIN;
               end
            end
         end
         S_DRAIN: begin
            if (!tx_busy) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge rd_clk) begin
      if (rd_rst) begin
         state_q     <= S_IDLE;
         timer_q     <= '0;
         remaining_q <= 16'd0;
         len_q       <= 16'd0;
         pkt_cnt_q   <= 16'd0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         timer_q     <= timer_d;
         remaining_q <= remaining_d;
         len_q       <= len_d;
         pkt_cnt_q   <= pkt_cnt_d;
         err_q       <= err_d;
      end
   end

   // The FIFO has no output register, so read data passes straight through.
   assign fifo_rd_en    = w_rd;
   assign tx_start_en   = (state_q == S_START);
   assign tx_byte_num   = len_q;
   assign tx_data       = fifo_rd_data;
   assign pkt_cnt       = pkt_cnt_q;
   assign err_underflow = err_q;

endmodule
`default_nettype wire

// File: tb/tb_udp_tx_fifo_reader.sv
`default_nettype none
// ============================================================================
// tb_udp_tx_fifo_reader : randomized scoreboard bench with FIFO and engine model
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_udp_tx_fifo_reader;

   localparam int LVL_WIDTH   = 12;
   localparam int MAX_PKT     = 32;
   localparam int TIMEOUT_CYC = 16;

   logic                 rd_clk = 1'b0;
   logic                 rd_rst;
   logic                 fifo_rd_en;
   logic [7:0]           fifo_rd_data;
   logic                 fifo_empty;
   logic [LVL_WIDTH-1:0] fifo_water_level;
   logic                 tx_busy;
   logic                 tx_req;
   logic                 tx_start_en;
   logic [15:0]          tx_byte_num;
   logic [7:0]           tx_data;
   logic [15:0]          pkt_cnt;
   logic                 err_underflow;

   int         checks   = 0;
   int         failures = 0;
   logic [7:0] fifo_q[$];
   logic [7:0] exp_q[$];
   int         lvl         = 0;
   logic       force_empty = 1'b0;
   logic       rd_s        = 1'b0;
   logic       acc_prev    = 1'b0;
   int         rd_total    = 0;
   int         pkt_exp     = 0;
   logic       uf_exp      = 1'b0;

   udp_tx_fifo_reader #(
      .LVL_WIDTH   (LVL_WIDTH),
      .MAX_PKT     (MAX_PKT),
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) dut (
      .rd_clk           (rd_clk),
      .rd_rst           (rd_rst),
      .fifo_rd_en       (fifo_rd_en),
      .fifo_rd_data     (fifo_rd_data),
      .fifo_empty       (fifo_empty),
      .fifo_water_level (fifo_water_level),
      .tx_busy          (tx_busy),
      .tx_req           (tx_req),
      .tx_start_en      (tx_start_en),
      .tx_byte_num      (tx_byte_num),
      .tx_data          (tx_data),
      .pkt_cnt          (pkt_cnt),
      .err_underflow    (err_underflow)
   );

   always #5 rd_clk = ~rd_clk;

   assign fifo_water_level = lvl[LVL_WIDTH-1:0];
   assign fifo_empty       = force_empty | (lvl == 0);

   task automatic check(input bit ok, input string name, input int act, input int req);
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
      end
   endtask

   // Scoreboard monitor: a byte accepted in one cycle must appear on tx_data the next.
   always @(negedge rd_clk) begin
      if (acc_prev) begin
         if (exp_q.size() == 0) begin
            check(1'b0, "tx_data_unexpected", int'(tx_data), -1);
         end else begin
            logic [7:0] e;
            e = exp_q.pop_front();
            check(tx_data == e, "tx_data", int'(tx_data), int'(e));
         end
      end
      acc_prev = fifo_rd_en;
      rd_s     = fifo_rd_en;
      if (fifo_rd_en) rd_total++;
   end

   // FIFO model without output register: data one cycle after read enable.
   always @(posedge rd_clk) begin
      if (rd_s && fifo_q.size() > 0) begin
         fifo_rd_data <= fifo_q.pop_front();
         lvl          <= fifo_q.size();
      end
   end

   task automatic tick();
      @(posedge rd_clk);
      #1;
   endtask

   task automatic push(input int n);
      for (int i = 0; i < n; i++) begin
         logic [7:0] b;
         b = 8'($urandom);
         fifo_q.push_back(b);
         exp_q.push_back(b);
      end
      lvl = fifo_q.size();
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge rd_clk);
         check(!tx_start_en, "no_start_idle", int'(tx_start_en), 0);
         tick();
      end
   endtask

   task automatic wait_start(output int lat);
      lat = 0;
      @(negedge rd_clk);
      while (!tx_start_en && lat < 300) begin
         tick();
         lat++;
         @(negedge rd_clk);
      end
      if (!tx_start_en) check(1'b0, "start_timeout", lat, 300);
   endtask

   // Engine model: one packet of len requests, extra request in DRAIN, busy tail.
   task automatic send_packet(input int len, input int lat_exp, input int gap_max,
                              input int tail, input int uf_idx);
      int lat;
      int acc0;
      wait_start(lat);
      if (!tx_start_en) return;
      pkt_exp++;
      if (uf_idx > 0) uf_exp = 1'b1;
      if (lat_exp >= 0) check(lat == lat_exp, "start_latency", lat, lat_exp);
      check(tx_byte_num == 16'(len), "tx_byte_num", int'(tx_byte_num), len);
      acc0 = rd_total;
      tick();
      tx_busy = 1'b1;
      for (int i = 0; i < len; i++) begin
         int gap;
         gap = $urandom_range(0, gap_max);
         repeat (gap) begin
            tx_req = 1'b0;
            force_empty = 1'b0;
            tick();
         end
         tx_req      = 1'b1;
         force_empty = (i == uf_idx - 1);
         @(negedge rd_clk);
         if (i == 0) check(!tx_start_en, "start_width", int'(tx_start_en), 0);
         tick();
      end
      tx_req      = 1'b1;
      force_empty = 1'b0;
      @(negedge rd_clk);
      check(!fifo_rd_en, "rd_en_after_last", int'(fifo_rd_en), 0);
      tick();
      tx_req = 1'b0;
      repeat (tail) begin
         @(negedge rd_clk);
         check(!tx_start_en, "drain_hold", int'(tx_start_en), 0);
         tick();
      end
      check(rd_total - acc0 == len, "rd_count", rd_total - acc0, len);
      check(err_underflow == uf_exp, "err_underflow", int'(err_underflow), int'(uf_exp));
      check(pkt_cnt == 16'(pkt_exp), "pkt_cnt", int'(pkt_cnt), pkt_exp);
      tx_busy = 1'b0;
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      rd_rst  = 1'b1;
      tx_busy = 1'b0;
      tx_req  = 1'b0;
      fifo_rd_data = 8'h00;
      repeat (3) tick();
      @(negedge rd_clk);
      check(!tx_start_en, "rst_start", int'(tx_start_en), 0);
      check(tx_byte_num == 16'd0, "rst_byte_num", int'(tx_byte_num), 0);
      check(pkt_cnt == 16'd0, "rst_pkt_cnt", int'(pkt_cnt), 0);
      check(!err_underflow, "rst_err", int'(err_underflow), 0);
      check(!fifo_rd_en, "rst_rd_en", int'(fifo_rd_en), 0);
      tick();
      rd_rst = 1'b0;

      // Full packet launches one cycle after the level reaches MAX_PKT.
      push(MAX_PKT);
      send_packet(MAX_PKT, 1, 0, 2, 0);
      idle(5);

      // Partial packet after the idle timeout.
      push(5);
      send_packet(5, TIMEOUT_CYC + 1, 1, 0, 0);
      idle(3);

      // Level dropping to zero restarts the timeout.
      push(5);
      repeat (10) begin
         @(negedge rd_clk);
         check(!tx_start_en, "timeout_early", int'(tx_start_en), 0);
         tick();
      end
      fifo_q.delete();
      exp_q.delete();
      lvl = 0;
      tick();
      push(5);
      send_packet(5, TIMEOUT_CYC + 1, 0, 1, 0);
      idle(3);

      // Sixteen bytes with back-to-back requests.
      push(16);
      send_packet(16, TIMEOUT_CYC + 1, 0, 0, 0);
      idle(3);

      // Busy gating in IDLE, then a long busy tail holding DRAIN.
      tx_busy = 1'b1;
      push(2 * MAX_PKT);
      repeat (40) begin
         @(negedge rd_clk);
         check(!tx_start_en, "busy_gate", int'(tx_start_en), 0);
         tick();
      end
      tx_busy = 1'b0;
      send_packet(MAX_PKT, 1, 0, 50, 0);
      send_packet(MAX_PKT, 2, 2, 3, 0);
      idle(3);

      // Underflow on the third request is sticky until reset.
      push(MAX_PKT);
      send_packet(MAX_PKT, 1, 1, 1, 3);
      idle(20);
      @(negedge rd_clk);
      check(err_underflow, "uf_sticky", int'(err_underflow), 1);
      tick();
      rd_rst = 1'b1;
      tick();
      rd_rst = 1'b0;
      pkt_exp = 0;
      uf_exp  = 1'b0;
      @(negedge rd_clk);
      check(!err_underflow, "uf_cleared", int'(err_underflow), 0);
      check(pkt_cnt == 16'd0, "pkt_cnt_cleared", int'(pkt_cnt), 0);
      tick();

      // Reset in the middle of a packet.
      push(MAX_PKT);
      wait_start(lat);
      tick();
      tx_busy = 1'b1;
      tx_req  = 1'b1;
      repeat (10) tick();
      rd_rst = 1'b1;
      tick();
      rd_rst = 1'b0;
      @(negedge rd_clk);
      check(!tx_start_en, "mid_rst_start", int'(tx_start_en), 0);
      check(tx_byte_num == 16'd0, "mid_rst_byte_num", int'(tx_byte_num), 0);
      check(pkt_cnt == 16'd0, "mid_rst_pkt_cnt", int'(pkt_cnt), 0);
      check(!err_underflow, "mid_rst_err", int'(err_underflow), 0);
      check(!fifo_rd_en, "mid_rst_req_ignored", int'(fifo_rd_en), 0);
      tick();
      tx_req  = 1'b0;
      tx_busy = 1'b0;
      push(MAX_PKT - fifo_q.size());
      send_packet(MAX_PKT, 1, 0, 2, 0);
      idle(3);

      // Random bursts: lengths and launch latency follow from the pushed byte count.
      repeat (15) begin
         int n;
         bit first;
         n = $urandom_range(1, 80);
         push(n);
         first = 1'b1;
         while (n > 0) begin
            int len;
            int lexp;
            len  = (n >= MAX_PKT) ? MAX_PKT : n;
            if (first) lexp = (n >= MAX_PKT) ? 1 : TIMEOUT_CYC + 1;
            else       lexp = (n >= MAX_PKT) ? 2 : TIMEOUT_CYC + 2;
            send_packet(len, lexp, $urandom_range(0, 2), $urandom_range(0, 4), 0);
            n     = n - len;
            first = 1'b0;
         end
         idle(2);
      end

      idle(5);
      check(exp_q.size() == 0, "all_bytes_delivered", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
